// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port RAM arbiter between CPU fetch (I) and data (D) ports
//
// Grants one RAM access at a time and holds address/data stable for RAM_LAT cycles.
// D wins contention unless I has lost STARVE_LIMIT consecutive times (0 = never force I).
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   iren, iaddr           fetch request / address (read-only port)
//   iwait, iload          fetch busy / fetch data
//   dren, dwen            data read / write request (both high = write)
//   daddr, dstore         data address / write data
//   dwait, dload          data busy / read data
//   ram_ren, ram_wen      RAM strobes, high for the whole access
//   ram_addr, ram_wdata   latched access address / write data
//   ram_rdata             RAM read data
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int RAM_LAT      = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iren,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dren,
  input  logic              dwen,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ram_ren,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int CNT_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
  localparam int ST_W  = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_IACC = 2'd1;
  localparam logic [1:0] S_DACC = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [ST_W-1:0]  starve;
  logic             wr;
  logic             done;
  logic             dreq;
  logic             force_i;
  logic             grant_i;
  logic             grant_d;

  assign dreq = dren | dwen;
  assign done = (state != S_IDLE) && (cnt == CNT_W'(RAM_LAT - 1));

  // I overrides D only once it has been passed over STARVE_LIMIT times in a row.
  assign force_i = (STARVE_LIMIT != 0) && (starve == ST_W'(STARVE_LIMIT));
  assign grant_i = (state == S_IDLE) && iren && (!dreq || force_i);
  assign grant_d = (state == S_IDLE) && dreq && !grant_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      starve    <= '0;
      wr        <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (grant_i) begin
            state    <= S_IACC;
            ram_addr <= iaddr;
            starve   <= '0;
          end else if (grant_d) begin
            state     <= S_DACC;
            ram_addr  <= daddr;
            ram_wdata <= dstore;
            wr        <= dwen;
            if (iren && (STARVE_LIMIT != 0) && (starve != ST_W'(STARVE_LIMIT)))
              starve <= starve + ST_W'(1);
          end
        end
        S_IACC, S_DACC: begin
          // Always returns through IDLE, giving one bubble between accesses.
          if (done) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Strobes decode straight from state so an asynchronous reset drops them at once.
  assign ram_ren = (state == S_IACC) || ((state == S_DACC) && !wr);
  assign ram_wen = (state == S_DACC) && wr;

  assign iwait = iren & !((state == S_IACC) && done);
  assign dwait = dreq & !((state == S_DACC) && done);
  assign iload = ram_rdata;
  assign dload = ram_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized self-checking bench for mem_arbiter
module tb_mem_arbiter;

  localparam int LAT = 2;
  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        iren, dren, dwen;
  logic [31:0] iaddr, daddr, dstore, ram_rdata;
  logic        iwait, dwait, ram_ren, ram_wen;
  logic [31:0] iload, dload, ram_addr, ram_wdata;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LAT(LAT), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .iren(iren), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dren(dren), .dwen(dwen), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    iren = 0; dren = 0; dwen = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  // Reference model: which port owns the RAM and how many access cycles remain.
  int          m_owner;   // 0 none, 1 I, 2 D
  int          m_left;
  bit          m_wr;
  logic [31:0] m_addr, m_wdata;
  int          m_starve;

  task automatic model_step();
    bit dq;
    dq = dren | dwen;
    if (m_owner != 0) begin
      m_left--;
      if (m_left == 0) m_owner = 0;
    end else if (iren && (!dq || (LIM != 0 && m_starve == LIM))) begin
      m_owner = 1; m_left = LAT; m_addr = iaddr; m_starve = 0;
    end else if (dq) begin
      m_owner = 2; m_left = LAT; m_addr = daddr; m_wdata = dstore; m_wr = dwen;
      if (iren && m_starve < LIM) m_starve++;
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    string       exp_seq;
    string       got_seq;
    bit          prev_busy;
    bit          e_iw, e_dw;
    iaddr = 0; daddr = 0; dstore = 0; ram_rdata = 0;

    // Reset values, and waits follow requests while reset is held.
    rst = 1'b1; iren = 1; dren = 0; dwen = 0;
    #1;
    check("rst_ren", ram_ren, 0);
    check("rst_wen", ram_wen, 0);
    check("rst_addr", ram_addr, 0);
    check("rst_wdata", ram_wdata, 0);
    check("rst_iwait", iwait, 1);
    check("rst_dwait_idle", dwait, 0);
    dwen = 1; #1;
    check("rst_dwait_req", dwait, 1);
    do_reset();

    // Single fetch.
    @(negedge clk);
    iren = 1; iaddr = 32'h100; ram_rdata = 32'hDEADBEEF; #1;
    check("f_c0_iwait", iwait, 1);
    check("f_c0_ren", ram_ren, 0);
    next_cycle();
    check("f_c1_iwait", iwait, 1);
    check("f_c1_ren", ram_ren, 1);
    check("f_c1_addr", ram_addr, 32'h100);
    next_cycle();
    check("f_c2_iwait", iwait, 0);
    check("f_c2_iload", iload, 32'hDEADBEEF);
    check("f_c2_ren", ram_ren, 1);
    iren = 0;
    next_cycle();
    check("f_c3_ren", ram_ren, 0);

    // Contention with starve=0: D first, bubble, then I.
    iren = 1; iaddr = 32'h300; dren = 1; daddr = 32'h200; #1;
    next_cycle();
    check("c_c1_addr", ram_addr, 32'h200);
    check("c_c1_ren", ram_ren, 1);
    check("c_c1_dwait", dwait, 1);
    next_cycle();
    check("c_c2_dwait", dwait, 0);
    check("c_c2_iwait", iwait, 1);
    dren = 0;
    next_cycle();
    check("c_c3_idle", ram_ren, 0);
    next_cycle();
    check("c_c4_ren", ram_ren, 1);
    check("c_c4_addr", ram_addr, 32'h300);
    check("c_c4_iwait", iwait, 1);
    next_cycle();
    check("c_c5_iwait", iwait, 0);
    iren = 0;
    next_cycle();

    // Write with dren also high; mid-access changes to address/data ignored.
    dwen = 1; dren = 1; daddr = 32'h40; dstore = 32'h12345678; #1;
    next_cycle();
    check("w_c1_wen", ram_wen, 1);
    check("w_c1_ren", ram_ren, 0);
    daddr = 32'hFFF0; dstore = 32'h0BADF00D;
    next_cycle();
    check("w_c2_addr", ram_addr, 32'h40);
    check("w_c2_wdata", ram_wdata, 32'h12345678);
    check("w_c2_dwait", dwait, 0);
    dwen = 0; dren = 0;
    next_cycle();
    check("w_c3_wen", ram_wen, 0);

    // Reset mid-write aborts asynchronously; the held request restarts in full.
    dwen = 1; daddr = 32'h80; dstore = 32'h55; #1;
    next_cycle();
    check("r_c1_wen", ram_wen, 1);
    #2 rst = 1'b1; #1;
    check("r_async_wen", ram_wen, 0);
    check("r_async_dwait", dwait, 1);
    @(negedge clk); rst = 1'b0; #1;
    check("r_idle_wen", ram_wen, 0);
    next_cycle();
    check("r_a1_wen", ram_wen, 1);
    check("r_a1_dwait", dwait, 1);
    next_cycle();
    check("r_a2_wen", ram_wen, 1);
    check("r_a2_dwait", dwait, 0);
    dwen = 0;
    next_cycle();
    check("r_a3_wen", ram_wen, 0);

    // Anti-starvation: both held continuously.
    do_reset();
    iaddr = 32'h1000; daddr = 32'h2000; iren = 1; dren = 1; #1;
    exp_seq = "DDDDID";
    got_seq = "";
    prev_busy = 0;
    for (int c = 0; c < 200 && got_seq.len() < 6; c++) begin
      next_cycle();
      if ((ram_ren || ram_wen) && !prev_busy)
        got_seq = {got_seq, (ram_addr == 32'h1000) ? "I" : "D"};
      prev_busy = ram_ren || ram_wen;
    end
    check("starve_count", got_seq.len(), 6);
    for (int k = 0; k < 6; k++)
      if (k < got_seq.len()) check($sformatf("starve_grant%0d", k), got_seq[k], exp_seq[k]);

    // Randomized traffic against the reference model.
    do_reset();
    m_owner = 0; m_left = 0; m_wr = 0; m_addr = 0; m_wdata = 0; m_starve = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      ram_rdata = $urandom;
      #1;
      e_iw = iren && !(m_owner == 1 && m_left == 1);
      e_dw = (dren || dwen) && !(m_owner == 2 && m_left == 1);
      check("rnd_ren", ram_ren, (m_owner == 1) || (m_owner == 2 && !m_wr));
      check("rnd_wen", ram_wen, (m_owner == 2) && m_wr);
      check("rnd_addr", ram_addr, m_addr);
      check("rnd_wdata", ram_wdata, m_wdata);
      check("rnd_iwait", iwait, e_iw);
      check("rnd_dwait", dwait, e_dw);
      if (iren && !e_iw) check("rnd_iload", iload, ram_rdata);
      if (dren && !dwen && !e_dw) check("rnd_dload", dload, ram_rdata);

      if (iren && !e_iw) begin
        iren = 1'($urandom % 2); iaddr = $urandom;
      end else if (!iren) begin
        if ($urandom % 3 == 0) begin iren = 1; iaddr = $urandom; end
      end else begin
        if ($urandom % 4 == 0) iaddr = $urandom;
        if ($urandom % 40 == 0) iren = 0;
      end

      if ((dren || dwen) && !e_dw) begin
        if ($urandom % 2 == 0) begin dren = 0; dwen = 0; end
        daddr = $urandom; dstore = $urandom;
      end else if (!(dren || dwen)) begin
        if ($urandom % 3 == 0) begin
          case ($urandom % 3)
            0: begin dren = 1; dwen = 0; end
            1: begin dren = 0; dwen = 1; end
            default: begin dren = 1; dwen = 1; end
          endcase
          daddr = $urandom; dstore = $urandom;
        end
      end else begin
        if ($urandom % 4 == 0) begin daddr = $urandom; dstore = $urandom; end
        if ($urandom % 40 == 0) begin dren = 0; dwen = 0; end
      end

      model_step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
